// File: rtl/mul_div_pkg.sv
// Shared constants, FSM encoding and flag struct for the RV32M multiply/divide unit.
// The divider-specific flag fields exist only when MUL_DIV_DIVIDE_EN is defined.
package mul_div_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam int unsigned ITER_COUNT = 32;
  localparam int unsigned LATENCY    = 34;
  localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  // Sign corrections decided when the operands are latched.
  typedef struct packed {
    logic neg_p;
`ifdef MUL_DIV_DIVIDE_EN
    logic neg_q;
    logic neg_r;
`endif
  } mdu_flags_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// FIX-stage logic: applies sign correction to the magnitude result and selects
// product half, quotient or remainder. Divide ops are gated by MUL_DIV_DIVIDE_EN.
module mdu_sign_fix
  import mul_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  mdu_flags_t      flags,
  output logic [XLEN-1:0] result,
  output logic            err
);

  logic [2*XLEN-1:0] prod;

  always_comb begin
    result = '0;
    err    = 1'b0;
    prod   = flags.neg_p ? (~{hi, lo} + (2*XLEN)'(1)) : {hi, lo};
    case (op)
      OP_MUL:                        result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod[2*XLEN-1:XLEN];
`ifdef MUL_DIV_DIVIDE_EN
      // Quotient accumulates in lo, remainder in hi.
      OP_DIV, OP_DIVU:               result = flags.neg_q ? (~lo + XLEN'(1)) : lo;
      OP_REM, OP_REMU:               result = flags.neg_r ? (~hi + XLEN'(1)) : hi;
`endif
      default: begin
        result = '0;
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiplier and restoring
// divider over operand magnitudes. Divider compiled in only with MUL_DIV_DIVIDE_EN.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] output_data1,
  input  logic [XLEN-1:0] input_alu,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            err,
  output mdu_state_e      state_dbg
);

  // Handshake: start is taken only in IDLE (and not while flush is high); busy is
  // high until the op retires; done pulses for one cycle with result/err valid,
  // and the next start is accepted from the following cycle onward.

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       op_q, op_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  m_q, m_d;
  mdu_flags_t       flags_q, flags_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             err_q, err_d;

  logic             a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [XLEN:0]    mul_sum;
  logic [XLEN:0]    div_sh;
  logic [XLEN-1:0]  fix_result;
  logic             fix_err;

  // MULHSU and MULHU treat B as unsigned; MULHU and the U divides treat A as unsigned.
  always_comb begin
    a_signed = (funct3 != OP_MULHU) && (funct3 != OP_DIVU) && (funct3 != OP_REMU);
    b_signed = a_signed && (funct3 != OP_MULHSU);
    a_neg    = a_signed && output_data1[XLEN-1];
    b_neg    = b_signed && input_alu[XLEN-1];
    a_mag    = a_neg ? (~output_data1 + XLEN'(1)) : output_data1;
    b_mag    = b_neg ? (~input_alu + XLEN'(1)) : input_alu;
  end

  mdu_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op     (op_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .flags  (flags_q),
    .result (fix_result),
    .err    (fix_err)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    flags_d  = flags_q;
    result_d = result_q;
    err_d    = err_q;
    mul_sum  = '0;
    div_sh   = '0;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d          = funct3;
          count_d       = '0;
          hi_d          = '0;
          flags_d       = '0;
          m_d           = a_mag;
          lo_d          = b_mag;
          flags_d.neg_p = a_neg ^ b_neg;
`ifdef MUL_DIV_DIVIDE_EN
          if (funct3[2]) begin
            m_d   = b_mag;
            lo_d  = a_mag;
            // Divide by zero keeps the all-ones quotient unsigned-looking.
            flags_d.neg_q = (a_neg ^ b_neg) && (input_alu != '0);
            flags_d.neg_r = a_neg;
          end
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        hi_d    = mul_sum[XLEN:1];
        lo_d    = {mul_sum[0], lo_q[XLEN-1:1]};
`ifdef MUL_DIV_DIVIDE_EN
        if (op_q[2]) begin
          div_sh = {hi_q, lo_q[XLEN-1]};
          if (div_sh >= {1'b0, m_q}) begin
            hi_d = div_sh[XLEN-1:0] - m_q;
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end
`endif
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(ITER_COUNT - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = fix_result;
        err_d    = fix_err;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // An aborted op must leave the visible result untouched.
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
      err_d    = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      flags_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      flags_q  <= flags_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit; divide expectations follow MUL_DIV_DIVIDE_EN.
module tb_mul_div_unit;
  import mul_div_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] output_data1;
  logic [31:0] input_alu;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        err;
  mdu_state_e  state_dbg;

  int          cyc;
  int          n_checks;
  int          n_bad;
  logic [31:0] last_exp;

  mul_div_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .funct3       (funct3),
    .output_data1 (output_data1),
    .input_alu    (input_alu),
    .flush        (flush),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .err          (err),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_done(input int limit, output int at);
    bit found;
    found = 1'b0;
    at    = -1;
    for (int i = 0; i < limit && !found; i++) begin
      if (done) begin
        found = 1'b1;
        at    = cyc;
      end else begin
        step();
      end
    end
  endtask

  // Issue one op, check latency, result and err, then move past the done cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_err);
    int c0;
    int at;
    funct3       = op;
    output_data1 = a;
    input_alu    = b;
    start        = 1'b1;
    c0           = cyc;
    step();
    start = 1'b0;
    wait_done(LATENCY + 6, at);
    check({tag, "_lat"}, 32'(at - c0), 32'(LATENCY));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    last_exp = exp_res;
    step();
  endtask

  initial begin
    int c0;
    int at;
    int done_cnt;
    cyc          = 0;
    n_checks     = 0;
    n_bad        = 0;
    last_exp     = '0;
    rst          = 1'b1;
    start        = 1'b0;
    flush        = 1'b0;
    funct3       = '0;
    output_data1 = '0;
    input_alu    = '0;
    step();
    step();
    rst = 1'b0;
    step();

    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_res", result, 32'd0);

    // multiply vectors
    run_op("mul_m1x2",    OP_MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b0);
    run_op("mulh_min",    OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    run_op("mulhu_min",   OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    run_op("mulhsu_m1",   OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op("mul_7xm3",    OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    run_op("mulh_7xm3",   OP_MULH,   32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    run_op("mulhu_max",   OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op("mul_big",     OP_MUL,    32'h00010001, 32'h00010001, 32'h00020001, 1'b0);

    // divide vectors
`ifdef MUL_DIV_DIVIDE_EN
    run_op("div_m7d2",    OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0);
    run_op("rem_m7d2",    OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0);
    run_op("divu_7d0",    OP_DIVU,   32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1'b0);
    run_op("remu_7d0",    OP_REMU,   32'h00000007, 32'h00000000, 32'h00000007, 1'b0);
    run_op("div_m7d0",    OP_DIV,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1'b0);
    run_op("rem_m7d0",    OP_REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b0);
    run_op("div_ovf",     OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    run_op("rem_ovf",     OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    run_op("divu_100d7",  OP_DIVU,   32'd100,      32'd7,        32'd14,       1'b0);
    run_op("rem_7dm2",    OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("div_7dm2",    OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
`else
    run_op("divu_nodiv",  OP_DIVU,   32'd10,       32'd3,        32'd0,        1'b1);
    run_op("rem_nodiv",   OP_REM,    32'hFFFFFFF9, 32'd2,        32'd0,        1'b1);
    run_op("mul_after",   OP_MUL,    32'd6,        32'd7,        32'd42,       1'b0);
`endif

    // flush mid-op: no done, result held, then a fresh op completes on time
    run_op("mul_pre_fl",  OP_MUL,    32'd9,        32'd9,        32'd81,       1'b0);
    done_cnt     = 0;
    funct3       = OP_MULHU;
    output_data1 = 32'hFFFFFFFF;
    input_alu    = 32'hFFFFFFFF;
    start        = 1'b1;
    c0           = cyc;
    step();
    start = 1'b0;
    while (cyc < c0 + 10) begin
      if (done) done_cnt++;
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_busy11", {31'b0, busy}, 32'd0);
    if (done) done_cnt++;
    step();
    funct3       = OP_MUL;
    output_data1 = 32'h12345678;
    input_alu    = 32'h00000010;
    start        = 1'b1;
    step();
    start = 1'b0;
    while (cyc <= c0 + 40) begin
      if (done) done_cnt++;
      step();
    end
    check("fl_nodone", 32'(done_cnt), 32'd0);
    check("fl_hold", result, last_exp);
    wait_done(20, at);
    check("fl_lat", 32'(at - c0), 32'd46);
    check("fl_res", result, 32'h23456780);
    step();

    // start while busy must not disturb the running op
    funct3       = OP_MULHU;
    output_data1 = 32'hFFFFFFFF;
    input_alu    = 32'hFFFFFFFF;
    start        = 1'b1;
    c0           = cyc;
    step();
    start = 1'b0;
    while (cyc < c0 + 5) step();
    funct3       = OP_MUL;
    output_data1 = 32'd3;
    input_alu    = 32'd3;
    start        = 1'b1;
    step();
    start = 1'b0;
    wait_done(40, at);
    check("bs_lat", 32'(at - c0), 32'(LATENCY));
    check("bs_res", result, 32'hFFFFFFFE);
    step();
    check("bs_idle", {31'b0, busy}, 32'd0);

    // flush together with start in IDLE: nothing starts
    funct3       = OP_MUL;
    output_data1 = 32'd2;
    input_alu    = 32'd2;
    start        = 1'b1;
    flush        = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b0;
    check("fs_busy", {31'b0, busy}, 32'd0);

    // reset mid-CALC
    funct3       = OP_MUL;
    output_data1 = 32'd5;
    input_alu    = 32'd5;
    start        = 1'b1;
    c0           = cyc;
    step();
    start = 1'b0;
    while (cyc < c0 + 20) step();
    check("rs_busy20", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rs_busy", {31'b0, busy}, 32'd0);
    check("rs_done", {31'b0, done}, 32'd0);
    check("rs_err", {31'b0, err}, 32'd0);
    check("rs_res", result, 32'd0);
    check("rs_state", {30'b0, state_dbg}, {30'b0, IDLE});
    done_cnt = 0;
    while (cyc <= c0 + 40) begin
      if (done) done_cnt++;
      step();
    end
    check("rs_nodone", 32'(done_cnt), 32'd0);

    // start in the same cycle as reset is ignored
    funct3       = OP_MUL;
    output_data1 = 32'd4;
    input_alu    = 32'd4;
    start        = 1'b1;
    rst          = 1'b1;
    step();
    start = 1'b0;
    rst   = 1'b0;
    check("rsst_busy", {31'b0, busy}, 32'd0);

    run_op("mul_post",    OP_MUL,    32'd4,        32'd4,        32'd16,       1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 output_data1  input  32  operand A (rs1).
REQ-007 input_alu  input  32  operand B, i.e. the ALU-source mux output.
REQ-008 flush  input  1  branch-mispredict abort.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse; result is valid this cycle.
REQ-011 result  output  32  operation result; held until the next done.
REQ-012 err  output  1  unsupported-op flag; qualified by done.

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIX, DONE.
REQ-014 IDLE with start=1 and flush=0 SHALL latch funct3 and both operands, load count=0, and enter CALC.
REQ-015 CALC SHALL run exactly 32 cycles, one iteration per cycle:
  - multiply: shift-add over operand magnitudes into a 64-bit product;
  - divide: restoring, one quotient bit per cycle.
REQ-016 After count=31, CALC SHALL enter FIX, which applies sign correction and selects the result half:
  - MUL: low 32 bits; MULH/MULHSU/MULHU: high 32 bits;
  - DIV/DIVU: quotient; REM/REMU: remainder.
REQ-017 FIX SHALL enter DONE; DONE SHALL assert done=1 and update result, then return to IDLE.
REQ-018 Latency: start sampled at edge N gives done=1 in cycle N+34 for every op, including the special cases below.
REQ-019 start while busy SHALL be ignored and SHALL NOT alter latched operands.
REQ-020 flush SHALL force IDLE at the next edge from any state:
  - done is not asserted for the aborted op;
  - result keeps its previous value.
REQ-021 flush and start together in IDLE: flush wins and no op starts.
REQ-022 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder equal to the dividend, signed and unsigned.
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-024 Sign rules:
  - MULHSU: operand A signed, B unsigned;
  - remainder takes the sign of the dividend;
  - quotient is truncated toward zero.
REQ-025 A back-to-back start is accepted at the earliest in the cycle after done.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, busy=0, done=0, err=0, result=0, count=0, from any state including mid-operation.
REQ-027 start asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-028 Macro MUL_DIV_DIVIDE_EN SHALL compile the divider path in.
REQ-029 With MUL_DIV_DIVIDE_EN defined: all eight ops execute per REQ-014..REQ-024, and err stays 0.
REQ-030 With MUL_DIV_DIVIDE_EN undefined: ops with funct3[2]=1 follow the same FSM and latency but give result 0 with err=1 at done; the divider logic is absent.

Structure
REQ-031 Shared package mul_div_pkg SHALL hold the funct3 op constants, FSM state encoding, iteration count (32) and total latency (34).
REQ-032 Sub-module mdu_sign_fix SHALL implement the combinational FIX-stage sign correction and half/quotient/remainder selection; everything else stays in mul_div_unit.

Verification
REQ-033 MUL 0xFFFFFFFF x 0x00000002, start at cycle 0 -> done at cycle 34, result 0xFFFFFFFE, err 0.
REQ-034 MULH 0x80000000 x 0x80000000 -> result 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-035 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 7 / 0 -> 0xFFFFFFFF; REM 0x80000000 / 0xFFFFFFFF -> 0.
REQ-036 start at cycle 0, flush at cycle 10 -> busy=0 at cycle 11, no done through cycle 40, result unchanged; a new start at cycle 12 completes at cycle 46.
REQ-037 rst at cycle 20 mid-CALC -> all outputs 0 at cycle 21; start pulsed at cycle 5 while busy -> no effect on the result.
REQ-038 Build without MUL_DIV_DIVIDE_EN, DIVU 10 / 3 -> done at cycle 34, result 0, err 1.
